// File: rtl/uart_index_receiver.sv
// Module-side decoder for two-byte sine-index UART frames: ID filter, range check,
// parity/timeout fault detection and a saturating fault counter.
module uart_index_receiver #(
    parameter logic [3:0] MODULE_ID    = 4'd1,
    parameter logic [3:0] BROADCAST_ID = 4'hF,
    parameter int         SINE_LEN     = 4096,
    parameter int         BYTE_TIMEOUT = 4800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    input  logic        parity_error,
    output logic [11:0] sin_index,
    output logic        index_valid,
    output logic        frame_error,
    output logic [7:0]  error_count
);

    localparam int              CW         = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [12:0]     SINE_LEN_C = 13'(SINE_LEN);
    localparam logic [CW-1:0]   TMO_LIMIT  = CW'(BYTE_TIMEOUT);

    typedef enum logic [0:0] {
        WAIT_HIGH = 1'b0,
        WAIT_LOW  = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [3:0]     id_r, id_s;
    logic [3:0]     hi_r, hi_s;
    logic [CW-1:0]  tmo_cnt_r, tmo_cnt_s, tmo_inc_s;
    logic [11:0]    sin_index_r, sin_index_s, idx_s;
    logic           index_valid_r, index_valid_s;
    logic           frame_error_r, frame_error_s;
    logic [7:0]     error_count_r, error_count_s;
    logic           id_match_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    // Frame reassembly, filtering, range check and timeout decisions
    always_comb begin
        state_s       = state_r;
        id_s          = id_r;
        hi_s          = hi_r;
        tmo_cnt_s     = tmo_cnt_r;
        sin_index_s   = sin_index_r;
        index_valid_s = 1'b0;
        frame_error_s = 1'b0;
        idx_s         = {hi_r, rx_byte};
        id_match_s    = (id_r == MODULE_ID) || (id_r == BROADCAST_ID);
        tmo_inc_s     = tmo_cnt_r + CW'(1);

        case (state_r)
            WAIT_HIGH: begin
                if (rx_done) begin
                    if (parity_error) begin
                        frame_error_s = 1'b1;
                    end else begin
                        id_s      = rx_byte[7:4];
                        hi_s      = rx_byte[3:0];
                        tmo_cnt_s = '0;
                        state_s   = WAIT_LOW;
                    end
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            WAIT_LOW: begin
                if (rx_done) begin
                    // A byte arriving on the limit cycle still completes the frame
                    state_s = WAIT_HIGH;
                    if (parity_error) begin
                        frame_error_s = 1'b1;
                    end else if (!id_match_s) begin
                        frame_error_s = 1'b0;
                    end else if ({1'b0, idx_s} >= SINE_LEN_C) begin
                        frame_error_s = 1'b1;
                    end else begin
                        sin_index_s   = idx_s;
                        index_valid_s = 1'b1;
                    end
                end else begin
                    tmo_cnt_s = tmo_inc_s;
                    if (tmo_inc_s == TMO_LIMIT) begin
                        frame_error_s = 1'b1;
                        state_s       = WAIT_HIGH;
                    end else begin
                        state_s = WAIT_LOW;
                    end
                end
            end
            default: begin
                state_s = WAIT_HIGH;
            end
        endcase

        if (frame_error_s) begin
            error_count_s = sat_inc8(error_count_r);
        end else begin
            error_count_s = error_count_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= WAIT_HIGH;
            id_r          <= 4'd0;
            hi_r          <= 4'd0;
            tmo_cnt_r     <= '0;
            sin_index_r   <= 12'd0;
            index_valid_r <= 1'b0;
            frame_error_r <= 1'b0;
            error_count_r <= 8'd0;
        end else begin
            state_r       <= state_s;
            id_r          <= id_s;
            hi_r          <= hi_s;
            tmo_cnt_r     <= tmo_cnt_s;
            sin_index_r   <= sin_index_s;
            index_valid_r <= index_valid_s;
            frame_error_r <= frame_error_s;
            error_count_r <= error_count_s;
        end
    end

    assign sin_index   = sin_index_r;
    assign index_valid = index_valid_r;
    assign frame_error = frame_error_r;
    assign error_count = error_count_r;

endmodule

// File: doc/uart_index_receiver.md
Name: uart_index_receiver

Overview:
- Module-side decoder for the sine-index frames the main FPGA broadcasts over UART.
- Sits after a uart_rx instance on each inverter-module FPGA.
- Reassembles the two-byte frame (byte 1 = {uart_id[3:0], sin_index[11:8]}, byte 2 = sin_index[7:0]), filters on module ID, range-checks the index and presents it with a one-cycle valid strobe.
- Detects framing faults: parity error, inter-byte timeout, out-of-range index.

Parameters:
- MODULE_ID, 4'd1, ID this module accepts.
- BROADCAST_ID, 4'hF, ID accepted by every module.
- SINE_LEN, 4096, number of table entries; valid index range 0..SINE_LEN-1.
- BYTE_TIMEOUT, 4800, max clk cycles allowed between byte 1 rx_done and byte 2 rx_done.

Ports:
- clk  in  1  system clock, same clock as the feeding uart_rx
- reset  in  1  asynchronous, active-low reset
- rx_byte  in  8  data_received from uart_rx; valid while rx_done=1
- rx_done  in  1  one-cycle strobe, byte received
- parity_error  in  1  qualifies rx_done; 1 = byte corrupt
- sin_index  out  12  last accepted index
- index_valid  out  1  one-cycle strobe, sin_index updated
- frame_error  out  1  one-cycle strobe, frame discarded on a fault
- error_count  out  8  saturating count of frame_error events

Behaviour:
- Reset (reset=0, asynchronous) drives the following:
  - state=WAIT_HIGH
  - sin_index=0, index_valid=0, frame_error=0, error_count=0
  - internal id/nibble/timeout registers cleared
- Reset mid-frame discards the partial frame; after release the block waits for a fresh byte 1.
- State machine WAIT_HIGH:
  - rx_done & !parity_error: latch id=rx_byte[7:4], hi=rx_byte[3:0]; clear timeout counter; go to WAIT_LOW.
  - rx_done & parity_error: pulse frame_error; stay in WAIT_HIGH.
  - No timeout runs in this state.
- State machine WAIT_LOW:
  - The timeout counter increments every cycle without rx_done.
  - rx_done & parity_error: pulse frame_error; go to WAIT_HIGH.
  - rx_done & !parity_error: form idx={hi, rx_byte}; go to WAIT_HIGH, then:
    - id not MODULE_ID and not BROADCAST_ID: drop silently, no strobe, no error.
    - id matches and idx >= SINE_LEN: pulse frame_error; sin_index unchanged.
    - id matches and idx < SINE_LEN: sin_index<=idx; pulse index_valid.
  - Counter reaches BYTE_TIMEOUT with no rx_done: pulse frame_error; go to WAIT_HIGH.
  - rx_done in the same cycle the counter reaches BYTE_TIMEOUT: rx_done wins; no timeout error.
- Latency: index_valid/frame_error are registered and assert on the clk edge following the rx_done cycle, or the timeout cycle. Each is high for exactly 1 cycle.
- index_valid and frame_error are never high in the same cycle.
- sin_index holds its value between strobes.
- error_count increments by 1 per frame_error cycle and saturates at 255; it never wraps.
- Back-to-back frames: byte 1 of the next frame may arrive the cycle after byte 2 completes; no dead cycles are required.
- The range check uses an unsigned compare at 13-bit width, so SINE_LEN=4096 accepts all 12-bit values.
- Timeout counter width is $clog2(BYTE_TIMEOUT+1); the counter never wraps.

Test Plan:
- Reset sequence: hold reset=0 for 5 cycles, then release -> all outputs 0. Then bytes 0x1A, 0x3C with no parity error -> sin_index=0xA3C, index_valid high for 1 cycle, one cycle after the second rx_done.
- ID filtering (MODULE_ID=1): frame 0x2F,0xFF -> no strobes, sin_index unchanged. Frame 0xF0,0x05 -> sin_index=0x005, index_valid pulse.
- Parity: byte 1 0x11 with parity_error=1 -> frame_error pulse, error_count=1. Next clean frame 0x10,0x20 -> sin_index=0x020. Also clean byte 1 then byte 2 with parity_error=1 -> frame_error pulse, sin_index unchanged.
- Timeout (BYTE_TIMEOUT=100): byte 0x12, then idle 100 cycles -> frame_error pulse, state WAIT_HIGH. Next byte 0x34 is then treated as byte 1, not byte 2. Boundary case: byte 2 arriving exactly on cycle 100 is accepted.
- Range (SINE_LEN=1000): frame 0x13,0xE7 (idx 999) -> accepted. Frame 0x13,0xE8 (idx 1000) -> frame_error, sin_index stays 999.
- Saturation and reset: inject 300 parity errors -> error_count=255. Assert reset between byte 1 and byte 2 -> error_count=0, and the subsequent lone byte 2 is treated as byte 1.
